// File: rtl/scu_dsp_dma_seq_pkg.sv
// Shared types and helpers for the SCU DSP DMA sequencer.
package scu_dsp_dma_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    FLUSH = 2'd2
  } dma_state_t;

  // Bank field sized for the largest supported bank count (8).
  typedef struct packed {
    logic       dir;
    logic       prg;
    logic [2:0] bank;
    logic       hold;
    logic [2:0] step;
  } dma_cfg_t;

  function automatic logic [8:0] dma_step(input logic [2:0] code, input logic hold);
    if (hold || code == 3'd0) return 9'd0;
    return 9'd4 << (code - 3'd1);
  endfunction

endpackage

// File: rtl/scu_dsp_dma_addr.sv
// External address register with stride/wrap, remaining-word counter and last-beat flag.
module scu_dsp_dma_addr #(
  parameter int EAW  = 27,
  parameter int CNTW = 8
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            clr,
  input  logic            load,
  input  logic            beat,
  input  logic [EAW-1:0]  load_addr,
  input  logic [CNTW-1:0] load_cnt,
  input  logic [8:0]      step,
  output logic [EAW-1:0]  addr,
  output logic            last
);
  localparam logic [CNTW:0] REM_ONE = (CNTW+1)'(1);

  logic [CNTW:0] rem;

  // A zero count encodes the full 2^CNTW words, hence the extra REM bit.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr <= '0;
      rem  <= '0;
    end else if (clr) begin
      addr <= '0;
      rem  <= '0;
    end else if (load) begin
      addr <= load_addr;
      rem  <= (load_cnt == '0) ? {1'b1, {CNTW{1'b0}}} : {1'b0, load_cnt};
    end else if (beat) begin
      addr <= addr + EAW'(step);
      rem  <= rem - REM_ONE;
    end
  end

  assign last = (rem == REM_ONE);

endmodule

// File: rtl/scu_dsp_dma_seq.sv
// SCU DSP DMA sequencer: moves word bursts between the SCU bus and DSP data/program RAM.
// state | meaning
// IDLE  | waiting for START on CE
// XFER  | bus request held, one word per acked CE_R beat
// FLUSH | all words moved, waiting for the arbiter end flag to fall
module scu_dsp_dma_seq
  import scu_dsp_dma_seq_pkg::*;
#(
  parameter int NBANK = 4,
  parameter int AW    = 6,
  parameter int DW    = 32,
  parameter int CNTW  = 8,
  parameter int EAW   = 27,
  parameter int PAW   = 8
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     CE,
  input  logic                     CE_R,
  input  logic                     CE_F,
  input  logic                     RES_N,
  input  logic                     START,
  input  logic                     START_DIR,
  input  logic                     START_PRG,
  input  logic [$clog2(NBANK)-1:0] START_BANK,
  input  logic [CNTW-1:0]          START_CNT,
  input  logic [EAW-1:0]           START_EADDR,
  input  logic [2:0]               START_STEP,
  input  logic                     START_HOLD,
  input  logic [NBANK*AW-1:0]      CT,
  output logic [NBANK-1:0]         CT_INC,
  input  logic [NBANK*DW-1:0]      BANK_RD,
  output logic [NBANK-1:0]         BANK_WE,
  output logic [DW-1:0]            BANK_WD,
  output logic                     PRG_WE,
  output logic [PAW-1:0]           PRG_ADDR,
  output logic [DW-1:0]            PRG_WD,
  input  logic [NBANK-1:0]         CORE_USE,
  input  logic                     CORE_HAZ,
  output logic                     PAUSE,
  output logic                     EXT_REQ,
  input  logic                     EXT_ACK,
  output logic [EAW-1:0]           EXT_ADDR,
  input  logic [DW-1:0]            EXT_DI,
  output logic [DW-1:0]            EXT_DO,
  output logic                     EXT_WE,
  output logic                     EXT_LAST,
  input  logic                     EXT_END,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     ERR_OVL
);
  localparam int BW = $clog2(NBANK);

  dma_state_t     state, state_nxt;
  dma_cfg_t       cfg;
  logic [PAW-1:0] prg_addr;
  logic           end_q, end_pend, pause_q, err_q;
  logic           last, busy, start_ok, beat, end_fall, done_ev;
  logic [BW-1:0]  bank_sel;
  logic           unused_ok;

  assign busy     = (state != IDLE);
  assign bank_sel = cfg.bank[BW-1:0];
  assign start_ok = RES_N & CE & START & (state == IDLE);
  assign beat     = RES_N & CE_R & EXT_ACK & (state == XFER);
  assign end_fall = CE_F & end_q & ~EXT_END;
  assign done_ev  = RES_N & CE & end_pend & (state == FLUSH);
  assign unused_ok = ^{CT, cfg.bank};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)      state <= IDLE;
    else if (!RES_N) state <= IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = XFER;
      XFER:    if (beat && last) state_nxt = FLUSH;
      FLUSH:   if (done_ev) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    EXT_REQ = (state == XFER);
    BUSY    = busy;
    DONE    = done_ev;
    CT_INC  = '0;
    BANK_WE = '0;
    BANK_WD = '0;
    PRG_WE  = 1'b0;
    PRG_WD  = '0;
    if (beat) begin
      if (cfg.prg) begin
        PRG_WE = 1'b1;
        PRG_WD = EXT_DI;
      end else begin
        CT_INC[bank_sel] = 1'b1;
        if (!cfg.dir) begin
          BANK_WE[bank_sel] = 1'b1;
          BANK_WD           = EXT_DI;
        end
      end
    end
    EXT_DO = cfg.dir ? BANK_RD[int'(bank_sel)*DW +: DW] : '0;
  end

  // End falls seen during XFER stay pending so FLUSH can complete on the next CE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cfg      <= '0;
      prg_addr <= '0;
      end_q    <= 1'b0;
      end_pend <= 1'b0;
      pause_q  <= 1'b0;
      err_q    <= 1'b0;
    end else if (!RES_N) begin
      cfg      <= '0;
      prg_addr <= '0;
      end_q    <= 1'b0;
      end_pend <= 1'b0;
      pause_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (CE_F) end_q <= EXT_END;
      if (start_ok) begin
        cfg.dir  <= START_DIR;
        cfg.prg  <= START_PRG & ~START_DIR;
        cfg.bank <= 3'(START_BANK);
        cfg.hold <= START_HOLD;
        cfg.step <= START_STEP;
        prg_addr <= '0;
      end else if (beat && cfg.prg) begin
        prg_addr <= prg_addr + PAW'(1);
      end
      if (!busy || done_ev) end_pend <= 1'b0;
      else if (end_fall)    end_pend <= 1'b1;
      if (!busy || done_ev) pause_q <= 1'b0;
      else if (CE_F)        pause_q <= CORE_USE[bank_sel] | CORE_HAZ;
      if (CE && START && busy) err_q <= 1'b1;
    end
  end

  scu_dsp_dma_addr #(.EAW(EAW), .CNTW(CNTW)) u_addr (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .clr       (~RES_N),
    .load      (start_ok),
    .beat      (beat),
    .load_addr (START_EADDR),
    .load_cnt  (START_CNT),
    .step      (dma_step(cfg.step, cfg.hold)),
    .addr      (EXT_ADDR),
    .last      (last)
  );

  assign EXT_LAST = last;
  assign EXT_WE   = cfg.dir;
  assign PRG_ADDR = prg_addr;
  assign PAUSE    = pause_q;
  assign ERR_OVL  = err_q;

endmodule

// File: tb/tb_scu_dsp_dma_seq.sv
// Randomized bench for scu_dsp_dma_seq against a transfer-level model, plus directed literal checks.
module tb_scu_dsp_dma_seq;
  localparam int NBANK = 4, AW = 6, DW = 32, CNTW = 8, EAW = 27, PAW = 8;

  logic CLK = 1'b0;
  logic RST_N, CE, CE_R, CE_F, RES_N, START, START_DIR, START_PRG, START_HOLD;
  logic [1:0] START_BANK;
  logic [CNTW-1:0] START_CNT;
  logic [EAW-1:0] START_EADDR;
  logic [2:0] START_STEP;
  logic [NBANK*AW-1:0] CT;
  logic [NBANK-1:0] CT_INC, BANK_WE, CORE_USE;
  logic [NBANK*DW-1:0] BANK_RD;
  logic [DW-1:0] BANK_WD, PRG_WD, EXT_DI, EXT_DO;
  logic PRG_WE, CORE_HAZ, PAUSE, EXT_REQ, EXT_ACK, EXT_WE, EXT_LAST, EXT_END, BUSY, DONE, ERR_OVL;
  logic [PAW-1:0] PRG_ADDR;
  logic [EAW-1:0] EXT_ADDR;

  always #5 CLK = ~CLK;

  scu_dsp_dma_seq #(.NBANK(NBANK), .AW(AW), .DW(DW), .CNTW(CNTW), .EAW(EAW), .PAW(PAW)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .CE_R(CE_R), .CE_F(CE_F), .RES_N(RES_N),
    .START(START), .START_DIR(START_DIR), .START_PRG(START_PRG), .START_BANK(START_BANK),
    .START_CNT(START_CNT), .START_EADDR(START_EADDR), .START_STEP(START_STEP), .START_HOLD(START_HOLD),
    .CT(CT), .CT_INC(CT_INC), .BANK_RD(BANK_RD), .BANK_WE(BANK_WE), .BANK_WD(BANK_WD),
    .PRG_WE(PRG_WE), .PRG_ADDR(PRG_ADDR), .PRG_WD(PRG_WD), .CORE_USE(CORE_USE), .CORE_HAZ(CORE_HAZ),
    .PAUSE(PAUSE), .EXT_REQ(EXT_REQ), .EXT_ACK(EXT_ACK), .EXT_ADDR(EXT_ADDR), .EXT_DI(EXT_DI),
    .EXT_DO(EXT_DO), .EXT_WE(EXT_WE), .EXT_LAST(EXT_LAST), .EXT_END(EXT_END), .BUSY(BUSY),
    .DONE(DONE), .ERR_OVL(ERR_OVL)
  );

  int n_cmp = 0, n_err = 0;

  // transfer-level model
  bit m_busy, m_dir, m_prg, m_endprev, m_endseen, m_pause, m_err;
  int m_left, m_bank, m_step;
  logic [EAW-1:0] m_addr;
  logic [PAW-1:0] m_prga;

  // stimulus knobs
  int ack_pct = 70, end_left = 0;
  bit fix_core = 0, fix_rd = 0;

  // observations
  logic [EAW-1:0] obs_addr[$];
  logic [PAW-1:0] obs_pa[$];
  logic obs_last[$];
  int cnt_bwe[NBANK], cnt_cti[NBANK];
  int cnt_pwe, cnt_done;

  logic [EAW-1:0] t1_addr[4] = '{27'h100, 27'h104, 27'h108, 27'h10C};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_dir = 0; m_prg = 0; m_endprev = 0; m_endseen = 0; m_pause = 0; m_err = 0;
    m_left = 0; m_bank = 0; m_step = 0; m_addr = '0; m_prga = '0;
  endtask

  task automatic clear_obs();
    obs_addr.delete(); obs_pa.delete(); obs_last.delete();
    for (int i = 0; i < NBANK; i++) begin cnt_bwe[i] = 0; cnt_cti[i] = 0; end
    cnt_pwe = 0; cnt_done = 0;
  endtask

  task automatic check_outputs();
    bit req, beat, done;
    logic [NBANK-1:0] oh;
    req  = m_busy && m_left > 0;
    beat = RES_N && CE_R && req && EXT_ACK;
    done = RES_N && CE && m_busy && m_left == 0 && m_endseen;
    oh = '0;
    oh[m_bank] = 1'b1;
    chk("ext_req", EXT_REQ, req);
    chk("busy", BUSY, m_busy);
    chk("ext_addr", EXT_ADDR, m_addr);
    chk("ext_last", EXT_LAST, m_busy && m_left == 1);
    chk("ct_inc", CT_INC, (beat && !m_prg) ? oh : '0);
    chk("bank_we", BANK_WE, (beat && !m_prg && !m_dir) ? oh : '0);
    chk("bank_wd", BANK_WD, (beat && !m_prg && !m_dir) ? EXT_DI : 32'h0);
    chk("prg_we", PRG_WE, beat && m_prg);
    chk("prg_wd", PRG_WD, (beat && m_prg) ? EXT_DI : 32'h0);
    chk("prg_addr", PRG_ADDR, m_prga);
    chk("ext_do", EXT_DO, m_dir ? BANK_RD[m_bank*DW +: DW] : 32'h0);
    chk("ext_we", EXT_WE, m_dir);
    chk("done", DONE, done);
    chk("pause", PAUSE, m_pause);
    chk("err_ovl", ERR_OVL, m_err);
    if (beat) begin
      obs_addr.push_back(EXT_ADDR);
      obs_last.push_back(EXT_LAST);
    end
    if (PRG_WE === 1'b1) obs_pa.push_back(PRG_ADDR);
    for (int i = 0; i < NBANK; i++) begin
      cnt_bwe[i] += int'(BANK_WE[i] === 1'b1);
      cnt_cti[i] += int'(CT_INC[i] === 1'b1);
    end
    cnt_pwe  += int'(PRG_WE === 1'b1);
    cnt_done += int'(DONE === 1'b1);
  endtask

  task automatic model_update();
    bit ob, beat, done;
    ob   = m_busy;
    beat = RES_N && CE_R && m_busy && m_left > 0 && EXT_ACK;
    done = RES_N && CE && ob && m_left == 0 && m_endseen;
    if (!RES_N) begin
      model_reset();
      return;
    end
    if (CE_F) begin
      if (ob && !done) m_pause = CORE_USE[m_bank] | CORE_HAZ;
      if (ob && m_endprev && !EXT_END) m_endseen = 1;
      m_endprev = EXT_END;
    end
    if (beat) begin
      m_left--;
      m_addr = m_addr + EAW'(m_step);
      if (m_prg) m_prga++;
    end
    if (done) begin m_busy = 0; m_endseen = 0; m_pause = 0; end
    if (CE && START) begin
      if (ob) m_err = 1;
      else begin
        m_busy = 1; m_endseen = 0;
        m_dir = START_DIR; m_prg = START_PRG && !START_DIR; m_bank = int'(START_BANK);
        m_step = (START_HOLD || START_STEP == 3'd0) ? 0 : 2 ** (int'(START_STEP) + 1);
        m_left = (START_CNT == '0) ? 256 : int'(START_CNT);
        m_addr = START_EADDR; m_prga = '0;
      end
    end
  endtask

  task automatic rand_inputs();
    CE   = $urandom_range(0, 99) < 60;
    CE_R = $urandom_range(0, 99) < 60;
    CE_F = $urandom_range(0, 99) < 50;
    EXT_ACK = $urandom_range(0, 99) < ack_pct;
    EXT_DI = $urandom;
    for (int i = 0; i < NBANK; i++) BANK_RD[i*DW +: DW] = $urandom;
    if (fix_rd) BANK_RD[3*DW +: DW] = 32'hDEADBEEF;
    if (!fix_core) begin
      CORE_USE = NBANK'($urandom);
      CORE_HAZ = $urandom_range(0, 7) == 0;
    end
    CT = (NBANK*AW)'($urandom);
    START = m_busy && ($urandom_range(0, 63) == 0);
    START_DIR = $urandom_range(0, 1) == 1;
    START_PRG = $urandom_range(0, 1) == 1;
    START_BANK = 2'($urandom);
    START_CNT = CNTW'($urandom);
    START_EADDR = EAW'($urandom);
    START_STEP = 3'($urandom);
    START_HOLD = $urandom_range(0, 1) == 1;
    if (!m_busy) EXT_END = 1'b1;
    else if (EXT_END && m_left <= end_left && $urandom_range(0, 1) == 1) EXT_END = 1'b0;
  endtask

  task automatic step_cycle();
    #3;
    check_outputs();
    model_update();
    @(posedge CLK);
    #1;
    rand_inputs();
  endtask

  task automatic prep_idle();
    for (int i = 0; i < 3; i++) begin CE_F = 1'b1; step_cycle(); end
    clear_obs();
  endtask

  task automatic start_xfer(input bit dir, input bit prg, input int bank, input int cnt,
                            input logic [EAW-1:0] ea, input int stp, input bit hold);
    START = 1'b1; CE = 1'b1;
    START_DIR = dir; START_PRG = prg; START_BANK = 2'(bank); START_CNT = CNTW'(cnt);
    START_EADDR = ea; START_STEP = 3'(stp); START_HOLD = hold;
    step_cycle();
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (m_busy && n < max_cyc) begin step_cycle(); n++; end
    if (m_busy) begin
      n_cmp++; n_err++;
      $display("FAIL timeout: transfer still busy after %0d cycles", max_cyc);
      RES_N = 1'b0; step_cycle(); RES_N = 1'b1;
    end
  endtask

  task automatic run_xfer(input bit dir, input bit prg, input int bank, input int cnt,
                          input logic [EAW-1:0] ea, input int stp, input bit hold, input int max_cyc);
    prep_idle();
    start_xfer(dir, prg, bank, cnt, ea, stp, hold);
    wait_idle(max_cyc);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    RST_N = 1'b0; RES_N = 1'b1; EXT_END = 1'b1; CORE_USE = '0; CORE_HAZ = 1'b0;
    model_reset(); clear_obs(); rand_inputs();
    repeat (3) @(posedge CLK);
    #2;
    chk("rst_busy", BUSY, 0);
    chk("rst_req", EXT_REQ, 0);
    chk("rst_err", ERR_OVL, 0);
    chk("rst_addr", EXT_ADDR, 0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    rand_inputs();

    // stride 4, bank 2 write
    run_xfer(0, 0, 2, 4, 27'h100, 1, 0, 2000);
    chk("t1_bwe2", cnt_bwe[2], 4);
    chk("t1_cti2", cnt_cti[2], 4);
    chk("t1_nbeats", obs_addr.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < obs_addr.size()) chk("t1_addr", obs_addr[i], t1_addr[i]);
    if (obs_last.size() == 4) begin
      chk("t1_last_first", obs_last[0], 0);
      chk("t1_last_fourth", obs_last[3], 1);
    end
    chk("t1_done", cnt_done, 1);

    // count 0 means 256 words, held address
    run_xfer(0, 0, 1, 0, 27'h2A0, 5, 1, 4000);
    chk("t2_beats", cnt_cti[1], 256);
    chk("t2_nobs", obs_addr.size(), 256);
    if (obs_addr.size() == 256) begin
      chk("t2_addr_first", obs_addr[0], 27'h2A0);
      chk("t2_addr_last", obs_addr[255], 27'h2A0);
    end

    // DSP -> external from bank 3
    fix_rd = 1;
    prep_idle();
    start_xfer(1, 0, 3, 5, 27'h40, 2, 0);
    #1;
    chk("t3_do", EXT_DO, 32'hDEADBEEF);
    chk("t3_we", EXT_WE, 1);
    wait_idle(2000);
    fix_rd = 0;
    chk("t3_bwe", cnt_bwe[0] + cnt_bwe[1] + cnt_bwe[2] + cnt_bwe[3], 0);
    chk("t3_cti3", cnt_cti[3], 5);

    // program RAM
    run_xfer(0, 1, 0, 3, 27'h800, 1, 0, 2000);
    chk("t4_pwe", cnt_pwe, 3);
    chk("t4_cti", cnt_cti[0] + cnt_cti[1] + cnt_cti[2] + cnt_cti[3], 0);
    chk("t4_npa", obs_pa.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < obs_pa.size()) chk("t4_pa", obs_pa[i], PAW'(i));

    // pause and overlapping start
    prep_idle();
    ack_pct = 0; fix_core = 1; CORE_USE = 4'b0100; CORE_HAZ = 1'b0;
    start_xfer(0, 0, 2, 6, 27'h1000, 3, 0);
    CE_F = 1'b1; step_cycle(); #1;
    chk("t5_pause_hit", PAUSE, 1);
    CORE_USE = 4'b0001; CE_F = 1'b1; step_cycle(); #1;
    chk("t5_pause_miss", PAUSE, 0);
    START = 1'b1; CE = 1'b1; step_cycle(); #1;
    chk("t5_err", ERR_OVL, 1);
    chk("t5_busy", BUSY, 1);
    fix_core = 0; ack_pct = 80;
    wait_idle(2000);
    chk("t5_bwe2", cnt_bwe[2], 6);
    if (obs_addr.size() == 6) chk("t5_addr_last", obs_addr[5], 27'h1000 + 27'd80);

    // soft reset after two beats
    prep_idle();
    ack_pct = 100;
    start_xfer(0, 0, 1, 5, 27'h300, 1, 0);
    for (int n = 0; n < 200 && obs_addr.size() < 2; n++) step_cycle();
    RES_N = 1'b0; step_cycle(); RES_N = 1'b1; #1;
    chk("t6_busy", BUSY, 0);
    chk("t6_req", EXT_REQ, 0);
    chk("t6_err", ERR_OVL, 0);
    chk("t6_bwe1", cnt_bwe[1], 2);
    chk("t6_done", cnt_done, 0);

    for (int t = 0; t < 25; t++) begin
      ack_pct = $urandom_range(20, 100);
      end_left = $urandom_range(0, 2);
      cnt = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 24);
      run_xfer($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom_range(0, 3), cnt,
               (t == 3) ? 27'h7FFFFF8 : EAW'($urandom), $urandom_range(0, 7), $urandom_range(0, 5) == 0, 3000);
      chk("rnd_done", cnt_done, 1);
      chk("rnd_beats", obs_addr.size(), (cnt == 0) ? 256 : cnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/scu_dsp_dma_seq.md
Name: scu_dsp_dma_seq

Overview:
Parametrised DMA sequencer for the SCU DSP family, successor to the single-channel fixed-width DSP DMA path.
- Moves CNT words between the external SCU bus and one of NBANK DSP data-RAM banks, or into program RAM.
- Supports programmable external address stride, an external-address hold mode and a counter-0 "max" encoding.
- Generates core pause requests on bank conflicts and a completion pulse.
- Sits between the DSP core (which issues START) and the SCU bus arbiter (request/ack).

Parameters:
NBANK, 4, number of data-RAM banks (power of two, 2..8)
AW, 6, data-RAM bank address width (bank depth 2^AW)
DW, 32, data word width
CNTW, 8, transfer counter width; START_CNT==0 means 2^CNTW words
EAW, 27, external byte address width
PAW, 8, program RAM address width

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
CE  in  1  DSP instruction clock enable
CE_R  in  1  bus rising-phase enable (all transfer beats)
CE_F  in  1  bus falling-phase enable (end detection, pause evaluation)
RES_N  in  1  synchronous soft reset (DSP reset bit), active-low
START  in  1  start transfer (sampled on CE)
START_DIR  in  1  0 = external->DSP, 1 = DSP->external
START_PRG  in  1  destination is program RAM (only valid with DIR=0)
START_BANK  in  $clog2(NBANK)  selected data bank
START_CNT  in  CNTW  word count
START_EADDR  in  EAW  external start byte address
START_STEP  in  3  external stride code
START_HOLD  in  1  external address hold (stride forced 0)
CT  in  NBANK*AW  current bank counters (flattened, bank 0 in LSBs)
CT_INC  out  NBANK  one-cycle counter increment strobes
BANK_RD  in  NBANK*DW  bank read data (flattened)
BANK_WE  out  NBANK  bank write strobes
BANK_WD  out  DW  bank write data
PRG_WE  out  1  program RAM write strobe
PRG_ADDR  out  PAW  program RAM write address
PRG_WD  out  DW  program RAM write data
CORE_USE  in  NBANK  banks referenced by the current core instruction
CORE_HAZ  in  1  core instruction is DMA/RA0W/WA0W (always conflicts)
PAUSE  out  1  core pause request
EXT_REQ  out  1  bus request
EXT_ACK  in  1  bus beat accepted
EXT_ADDR  out  EAW  current external byte address
EXT_DI  in  DW  read data from bus
EXT_DO  out  DW  write data to bus
EXT_WE  out  1  bus direction (equals latched DIR)
EXT_LAST  out  1  current beat is the final one
EXT_END  in  1  arbiter end flag; its falling edge completes the transfer
BUSY  out  1  T0 status flag
DONE  out  1  one-CE pulse on completion
ERR_OVL  out  1  sticky: START received while BUSY

Behaviour:
- Reset (RST_N low, or RES_N low on any clock): state IDLE. All outputs 0: EXT_REQ, BUSY, DONE, PAUSE, ERR_OVL, all strobes, counters and latched fields.
- States: IDLE, XFER, FLUSH.
  - IDLE -> XFER on CE&START. Latch DIR, PRG, BANK, HOLD and EADDR.
  - On entry to XFER: REM = START_CNT, with 0 mapped to 2^CNTW (REM is CNTW+1 bits). PRG_ADDR = 0. BUSY = 1, EXT_REQ = 1 on the next clock.
- Stride: step = HOLD or code 0 -> 0; else 4 << (code-1) bytes, i.e. 4, 8, 16, 32, 64, 128, 256. EXT_ADDR wraps modulo 2^EAW.
- Beat: each CE_R with EXT_REQ&EXT_ACK is one beat. On that cycle:
  - REM decrements and EXT_ADDR += step.
  - CT_INC[BANK] pulses when PRG=0.
  - If PRG=1: PRG_WE pulses and PRG_ADDR increments, wrapping at 2^PAW.
  - DIR=0, PRG=0: BANK_WE[BANK] = 1, BANK_WD = EXT_DI.
  - DIR=1: EXT_DO = BANK_RD[BANK] combinationally.
  - EXT_LAST = (REM == 1).
  - After the beat where REM reaches 0, EXT_REQ drops on the same clock edge and the state moves to FLUSH.
- FLUSH: the falling edge of EXT_END (sampled on CE_F) sets an end-pending flag. On the next CE: BUSY = 0, DONE pulses for that CE, state returns to IDLE.
- EXT_END falling while in XFER is recorded and honoured on entry to FLUSH, so no completion is lost.
- PAUSE is evaluated on CE_F while BUSY: PAUSE = CORE_USE[BANK] | CORE_HAZ. PAUSE = 0 when not BUSY. PAUSE clears together with BUSY.
- START while BUSY: ignored, ERR_OVL set. A START arriving on the same CE as the DONE pulse is also ignored (BUSY is still 1). ERR_OVL clears only on reset.
- START_PRG with DIR=1 is treated as DIR=1 data transfer; PRG is ignored.
- Latency: START (CE) -> EXT_REQ is 1 clock. Final ACK -> DONE is at least 1 CE after EXT_END falls.

Decomposition:
- Shared package SCUDSP_PKG gains:
  - typedef DMACfg_t holding the latched DIR/PRG/BANK/HOLD/STEP fields;
  - enum DMAState_t (IDLE, XFER, FLUSH);
  - function DmaStep(code, hold) returning the byte stride.
- One sub-module, scu_dsp_dma_addr: external address register with stride add and wrap, plus the REM counter and LAST generation.

Test Plan:
- DIR=0, BANK=2, CNT=4, EADDR=0x100, STEP=1, ACK every beat -> BANK_WE[2] pulses 4 times, CT_INC[2] 4 pulses, EXT_ADDR 0x100/0x104/0x108/0x10C, EXT_LAST on 4th beat, DONE after EXT_END falls.
- CNT=0, HOLD=1 -> exactly 256 beats, EXT_ADDR stays constant, BUSY high throughout.
- DIR=1, BANK=3, BANK_RD[3]=0xDEADBEEF -> EXT_DO=0xDEADBEEF, EXT_WE=1, no BANK_WE.
- PRG=1, CNT=3 -> PRG_WE at PRG_ADDR 0, 1, 2; no CT_INC.
- BUSY with CORE_USE=4'b0100, BANK=2 -> PAUSE=1 on next CE_F; CORE_USE=4'b0001 -> PAUSE=0; START while busy -> ERR_OVL=1, transfer unaffected.
- RES_N low mid-XFER after 2 of 5 beats -> EXT_REQ=0, BUSY=0 next clock, no DONE pulse.
